usb_fx3_slfifo_writer: RTL and testbench
========================================

# usb_fx3_slfifo_writer

Transmit-side bridge from an AXI4-Stream source to a Cypress FX3 GPIF II slave FIFO write port (synchronous, 32-bit or 16-bit bus). It sits at the USB3.0 egress end of the data path: upstream logic and the AXIS width converter deliver packets at bus width, and this block turns them into slave-FIFO write strobes. It handles DMA-buffer flow control, watermark throttling, buffer switchover and short-packet commit.

## Interface
Parameters:
- TDATA_WIDTH, 4, stream and FX3 bus width in bytes; legal values 2 or 4.
- BUF_WORDS, 256, FX3 DMA buffer size in bus words; power of two, 4–4096.
- WM_BEATS, 3, writes still permitted after the registered partial flag is seen low; 1–15.
- SWITCH_CYCLES, 4, idle cycles after a buffer commit before the flags are trusted again; 1–15.
- FIFO_ADDR, 2'b00, FX3 socket address driven on fifoaddr.

Ports:
- aclk  in  1  clock; same clock as FX3 PCLK.
- areset  in  1  synchronous reset, active-high.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- s_axis_tdata  in  TDATA_WIDTH*8  stream data.
- s_axis_tkeep  in  TDATA_WIDTH  byte qualifiers; all ones except on the tlast beat.
- s_axis_tlast  in  1  end of packet.
- flaga  in  1  FX3 DMA-ready flag; 1 means a buffer is available.
- flagb  in  1  FX3 partial flag, active-low; 0 means the watermark has been reached.
- slcs_n  out  1  chip select.
- slwr_n  out  1  write strobe.
- slrd_n  out  1  read strobe; held 1.
- sloe_n  out  1  output enable; held 1.
- pktend_n  out  1  packet end.
- fifoaddr  out  2  socket address.
- dq  out  TDATA_WIDTH*8  FX3 data bus.
- err_keep  out  1  one-cycle pulse on protocol error.

## Operation
- flaga and flagb are registered once internally as flaga_r and flagb_r. All decisions use the registered copies.
- Internal counters:
  - buf_cnt: width clog2(BUF_WORDS); words written into the current DMA buffer.
  - budget: 4 bits; remaining writes allowed after the watermark.
  - sw_cnt: 4 bits; switchover wait.
- FSM states:
  - IDLE: s_axis_tready=0. Go to WRITE when flaga_r=1. buf_cnt=0, budget=WM_BEATS.
  - WRITE: s_axis_tready = flaga_r and not (flagb_r=0 and budget=0). It is derived from registers only and never depends on s_axis_tvalid. On each accepted beat (tvalid and tready):
    - buf_cnt increments.
    - budget decrements if flagb_r=0.
    - If the beat has tlast, or buf_cnt=BUF_WORDS-1, go to SWITCH with sw_cnt=SWITCH_CYCLES-1. Otherwise stay in WRITE.
  - SWITCH: s_axis_tready=0. Decrement sw_cnt. At 0, go to IDLE. buf_cnt and budget reload as in IDLE.
- Write output, registered from the accepted beat:
  - slwr_n=0 for exactly one cycle per accepted beat.
  - dq = tdata with each byte whose tkeep bit is 0 forced to 0x00.
  - On cycles with no accepted beat, slwr_n=1 and dq holds its last value.
- pktend_n:
  - Driven 0 together with the slwr_n strobe of a tlast beat when that beat does not fill the buffer (buf_cnt≠BUF_WORDS-1 at acceptance). This is a short-packet commit.
  - If the tlast beat fills the buffer exactly, pktend_n stays 1 and FX3 auto-commits.
- err_keep:
  - Pulses (registered) when a beat is accepted with tlast=0 and tkeep not all ones, or with tlast=1 and tkeep=0.
  - The beat is still written.
- If flaga_r falls mid-buffer, writing stalls in WRITE. buf_cnt is preserved and writing resumes when flaga_r returns.
- slcs_n=1 during reset, 0 from the first cycle after reset. fifoaddr=FIFO_ADDR at all times. slrd_n and sloe_n are constant 1.

## Timing
- Reset values:
  - s_axis_tready=0, slcs_n=1, slwr_n=1, slrd_n=1, sloe_n=1, pktend_n=1.
  - fifoaddr=FIFO_ADDR, dq=0, err_keep=0, state IDLE.
  - A reset asserted mid-packet abandons the packet; no pktend is issued.
- Latencies:
  - Beat accepted in cycle N gives slwr_n=0, dq and pktend_n valid in cycle N+1.
  - flaga pin rising in cycle N makes flaga_r=1 in N+1, the FSM enters WRITE in N+2, and the earliest accept is in N+2.
  - flagb pin falling in cycle N makes flagb_r=0 in N+1. At most WM_BEATS further accepts follow, then tready drops in the same cycle budget reaches 0.
- Sustained throughput: one word per cycle while flaga_r=1 and flagb_r=1.
- Buffer overhead: SWITCH lasts exactly SWITCH_CYCLES cycles, plus one IDLE cycle minimum.
- If flagb_r=0 and budget=0 in the same cycle a beat is offered, that beat is not accepted.
- If tlast and the buffer-full condition coincide, the block goes to SWITCH once and pktend_n stays 1.

## Test plan
- Reset, then flaga=1, flagb=1, TDATA_WIDTH=4, 10-beat packet of data 0x00000001..0x0000000A, tkeep=F -> 10 consecutive slwr_n strobes carrying the same values; pktend_n=0 only on the 10th strobe; 4 tready-low cycles, then IDLE.
- BUF_WORDS=8, 20-beat packet -> strobes are grouped 8, 8, 4 with a SWITCH gap after each group; pktend_n=0 only on the final (4th-word) strobe.
- 8-beat packet with BUF_WORDS=8 -> no pktend_n assertion; one SWITCH follows.
- flagb pulled low after beat 3, tvalid held high, WM_BEATS=3 -> exactly 3 more accepts after flagb_r falls, then tready=0 until buffer switchover.
- Last beat tkeep=4'b0011, tdata=0xAABBCCDD -> dq=0x0000CCDD with pktend_n=0. A mid-packet beat with tkeep=4'b0111 -> one err_keep pulse; the beat is still written.
- flaga dropped for 5 cycles mid-buffer, then areset asserted mid-packet -> writing stalls while flaga is low and resumes; on reset all outputs return to reset values the next cycle with no pktend strobe.

Source files
------------

// File: rtl/usb_fx3_slfifo_writer.sv
// AXI4-Stream to Cypress FX3 GPIF II synchronous slave-FIFO write bridge.
// Accepts bus-width beats and turns each one into a single slwr_n strobe.
// It tracks DMA-buffer fill, throttles on the partial (watermark) flag,
// waits out buffer switchover, and issues pktend_n for short packets.
//
// Handshake: a beat transfers on a rising aclk edge where s_axis_tvalid and
// s_axis_tready are both 1. s_axis_tready comes only from registered state,
// so it never depends on s_axis_tvalid. The source must hold a beat steady
// until it is accepted.
module usb_fx3_slfifo_writer #(
    parameter int         TDATA_WIDTH   = 4,
    parameter int         BUF_WORDS     = 256,
    parameter int         WM_BEATS      = 3,
    parameter int         SWITCH_CYCLES = 4,
    parameter logic [1:0] FIFO_ADDR     = 2'b00
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [TDATA_WIDTH*8-1:0] s_axis_tdata,
    input  logic [TDATA_WIDTH-1:0]   s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic                     flaga,
    input  logic                     flagb,
    output logic                     slcs_n,
    output logic                     slwr_n,
    output logic                     slrd_n,
    output logic                     sloe_n,
    output logic                     pktend_n,
    output logic [1:0]               fifoaddr,
    output logic [TDATA_WIDTH*8-1:0] dq,
    output logic                     err_keep,
    output logic [1:0]               dbg_state
);

    localparam int             DW       = TDATA_WIDTH * 8;
    localparam int             CW       = $clog2(BUF_WORDS);
    localparam logic [CW-1:0]  BUF_LAST = CW'(BUF_WORDS - 1);
    localparam logic [3:0]     WM_INIT  = 4'(WM_BEATS);
    localparam logic [3:0]     SW_INIT  = 4'(SWITCH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_flaga;
    logic            r_flagb;
    logic [CW-1:0]   r_buf_cnt;
    logic [3:0]      r_budget;
    logic [3:0]      r_sw_cnt;
    logic            r_slcs_n;
    logic            r_slwr_n;
    logic            r_pktend_n;
    logic [DW-1:0]   r_dq;
    logic            r_err_keep;

    logic            w_tready;
    logic            w_accept;
    logic            w_buf_last;
    logic            w_keep_err;
    logic [DW-1:0]   w_dq_masked;

    assign w_accept   = w_tready && s_axis_tvalid;
    assign w_buf_last = (r_buf_cnt == BUF_LAST);
    // Only the final beat of a packet may carry a partial tkeep, and it must
    // still carry at least one byte.
    assign w_keep_err = s_axis_tlast ? (s_axis_tkeep == '0) : (s_axis_tkeep != '1);

    // Register the FX3 flags once; every decision uses these copies.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_flaga <= 1'b0;
            r_flagb <= 1'b1;
        end else begin
            r_flaga <= flaga;
            r_flagb <= flagb;
        end
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and ready decode; ready only in WRITE, gated by the flags.
    always_comb begin
        w_next_state = r_state;
        w_tready     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_flaga) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_tready = r_flaga && !(!r_flagb && (r_budget == 4'd0));
                if (w_tready && s_axis_tvalid && (s_axis_tlast || w_buf_last)) begin
                    w_next_state = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (r_sw_cnt == 4'd0) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Buffer fill, watermark budget and switchover counters.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_buf_cnt <= '0;
            r_budget  <= WM_INIT;
            r_sw_cnt  <= 4'd0;
        end else begin
            unique case (r_state)
                ST_WRITE: begin
                    if (w_accept) begin
                        r_buf_cnt <= r_buf_cnt + 1'b1;
                        if (!r_flagb) begin
                            r_budget <= r_budget - 4'd1;
                        end
                        if (w_next_state == ST_SWITCH) begin
                            r_sw_cnt <= SW_INIT;
                        end
                    end
                end
                ST_SWITCH: begin
                    r_buf_cnt <= '0;
                    r_budget  <= WM_INIT;
                    if (r_sw_cnt != 4'd0) begin
                        r_sw_cnt <= r_sw_cnt - 4'd1;
                    end
                end
                default: begin
                    r_buf_cnt <= '0;
                    r_budget  <= WM_INIT;
                end
            endcase
        end
    end

    // Zero the bytes whose tkeep bit is clear before they reach the bus.
    always_comb begin
        w_dq_masked = '0;
        for (int i = 0; i < TDATA_WIDTH; i++) begin
            if (s_axis_tkeep[i]) begin
                w_dq_masked[i*8 +: 8] = s_axis_tdata[i*8 +: 8];
            end
        end
    end

    // Registered bus side: one write strobe per accepted beat, data held otherwise.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_slcs_n   <= 1'b1;
            r_slwr_n   <= 1'b1;
            r_pktend_n <= 1'b1;
            r_dq       <= '0;
            r_err_keep <= 1'b0;
        end else begin
            r_slcs_n   <= 1'b0;
            r_slwr_n   <= !w_accept;
            // A tlast beat that fills the buffer is auto-committed by FX3.
            r_pktend_n <= !(w_accept && s_axis_tlast && !w_buf_last);
            r_err_keep <= w_accept && w_keep_err;
            if (w_accept) begin
                r_dq <= w_dq_masked;
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign slcs_n        = r_slcs_n;
    assign slwr_n        = r_slwr_n;
    assign slrd_n        = 1'b1;
    assign sloe_n        = 1'b1;
    assign pktend_n      = r_pktend_n;
    assign fifoaddr      = FIFO_ADDR;
    assign dq            = r_dq;
    assign err_keep      = r_err_keep;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_usb_fx3_slfifo_writer.sv
// Directed bench for usb_fx3_slfifo_writer.
// dut_a uses the default 256-word buffer; dut_b uses an 8-word buffer and
// socket address 2'b10. A select line routes the shared stimulus to one of
// them, and the other sees an idle source with flaga low.
module tb_usb_fx3_slfifo_writer;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;
    logic        sel;
    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        flaga;
    logic        flagb;

    logic a_tvalid, a_flaga, a_flagb;
    logic b_tvalid, b_flaga, b_flagb;
    assign a_tvalid = !sel && tvalid;
    assign a_flaga  = !sel && flaga;
    assign a_flagb  = sel || flagb;
    assign b_tvalid = sel && tvalid;
    assign b_flaga  = sel && flaga;
    assign b_flagb  = !sel || flagb;

    logic        a_tready, a_slcs_n, a_slwr_n, a_slrd_n, a_sloe_n, a_pktend_n, a_err;
    logic [1:0]  a_fifoaddr, a_dbg;
    logic [31:0] a_dq;
    logic        b_tready, b_slcs_n, b_slwr_n, b_slrd_n, b_sloe_n, b_pktend_n, b_err;
    logic [1:0]  b_fifoaddr, b_dbg;
    logic [31:0] b_dq;

    usb_fx3_slfifo_writer dut_a (
        .aclk(clk), .areset(areset),
        .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .flaga(a_flaga), .flagb(a_flagb),
        .slcs_n(a_slcs_n), .slwr_n(a_slwr_n), .slrd_n(a_slrd_n), .sloe_n(a_sloe_n),
        .pktend_n(a_pktend_n), .fifoaddr(a_fifoaddr), .dq(a_dq),
        .err_keep(a_err), .dbg_state(a_dbg)
    );

    usb_fx3_slfifo_writer #(.BUF_WORDS(8), .FIFO_ADDR(2'b10)) dut_b (
        .aclk(clk), .areset(areset),
        .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .flaga(b_flaga), .flagb(b_flagb),
        .slcs_n(b_slcs_n), .slwr_n(b_slwr_n), .slrd_n(b_slrd_n), .sloe_n(b_sloe_n),
        .pktend_n(b_pktend_n), .fifoaddr(b_fifoaddr), .dq(b_dq),
        .err_keep(b_err), .dbg_state(b_dbg)
    );

    logic        w_tready, w_slcs_n, w_slwr_n, w_slrd_n, w_sloe_n, w_pktend_n, w_err;
    logic [1:0]  w_fifoaddr, w_dbg;
    logic [31:0] w_dq;
    assign w_tready   = sel ? b_tready   : a_tready;
    assign w_slcs_n   = sel ? b_slcs_n   : a_slcs_n;
    assign w_slwr_n   = sel ? b_slwr_n   : a_slwr_n;
    assign w_slrd_n   = sel ? b_slrd_n   : a_slrd_n;
    assign w_sloe_n   = sel ? b_sloe_n   : a_sloe_n;
    assign w_pktend_n = sel ? b_pktend_n : a_pktend_n;
    assign w_err      = sel ? b_err      : a_err;
    assign w_fifoaddr = sel ? b_fifoaddr : a_fifoaddr;
    assign w_dbg      = sel ? b_dbg      : a_dbg;
    assign w_dq       = sel ? b_dq       : a_dq;

    // ---------------- monitor ----------------
    int          cyc = 0;
    logic [33:0] obs_q[$];
    int          obs_cyc_q[$];
    int          err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (w_slwr_n === 1'b0) begin
            obs_q.push_back({w_pktend_n, w_err, w_dq});
            obs_cyc_q.push_back(cyc);
        end
        if (w_err === 1'b1) err_cnt++;
    end

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    int          obs_base = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic pk_n, input logic err);
        exp_q.push_back({pk_n, err, d});
    endtask

    task automatic compare_strobes(input string tag);
        int n_obs;
        n_obs = obs_q.size() - obs_base;
        chk({tag, "_count"}, 32'(n_obs), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n_obs) begin
                chk($sformatf("%s_dq%0d", tag, i), obs_q[obs_base+i][31:0], exp_q[i][31:0]);
                chk($sformatf("%s_pk_err%0d", tag, i), 32'(obs_q[obs_base+i][33:32]),
                    32'(exp_q[i][33:32]));
            end
        end
        obs_base = obs_q.size();
        exp_q.delete();
    endtask

    // Strobe i follows strobe i-1 by one cycle, or by 6 across a buffer switch.
    task automatic check_gaps(input string tag, input int n, input int g1, input int g2);
        for (int i = 1; i < n; i++) begin
            if (obs_base + i < obs_cyc_q.size()) begin
                int d;
                d = obs_cyc_q[obs_base+i] - obs_cyc_q[obs_base+i-1];
                chk($sformatf("%s_gap%0d", tag, i), 32'(d),
                    (i == g1 || i == g2) ? 32'd6 : 32'd1);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int waited;
        waited = 0;
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        @(negedge clk);
        while (w_tready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) chk($sformatf("tready_wait_%h", d), 32'(w_tready), 32'd1);
        @(posedge clk); #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // Called right after a buffer-ending accept: 4 SWITCH cycles, then IDLE.
    task automatic check_switch(input string tag);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("%s_sw_state%0d", tag, c), 32'(w_dbg), 32'(ST_SWITCH));
            chk($sformatf("%s_sw_tready%0d", tag, c), 32'(w_tready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_idle"}, 32'(w_dbg), 32'(ST_IDLE));
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag, input logic [1:0] addr);
        chk({tag, "_state"}, 32'(w_dbg), 32'(ST_IDLE));
        chk({tag, "_tready"}, 32'(w_tready), 32'd0);
        chk({tag, "_slcs_n"}, 32'(w_slcs_n), 32'd1);
        chk({tag, "_slwr_n"}, 32'(w_slwr_n), 32'd1);
        chk({tag, "_slrd_n"}, 32'(w_slrd_n), 32'd1);
        chk({tag, "_sloe_n"}, 32'(w_sloe_n), 32'd1);
        chk({tag, "_pktend_n"}, 32'(w_pktend_n), 32'd1);
        chk({tag, "_fifoaddr"}, 32'(w_fifoaddr), 32'(addr));
        chk({tag, "_dq"}, w_dq, 32'd0);
        chk({tag, "_err_keep"}, 32'(w_err), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int guard;
        int err_base;

        areset = 1'b1; sel = 1'b0; tvalid = 1'b0; tlast = 1'b0;
        tdata = 32'd0; tkeep = 4'h0; flaga = 1'b0; flagb = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset values on both instances.
        @(negedge clk);
        chk_reset_outputs("rst_a", 2'b00);
        @(posedge clk); #1;
        sel = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_b", 2'b10);
        @(posedge clk); #1;
        sel = 1'b0;
        areset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("slcs_after_reset", 32'(w_slcs_n), 32'd0);
        @(posedge clk); #1;

        // T1 (dut_a): flaga latency, then a 10-beat short packet.
        flaga = 1'b1; tvalid = 1'b1; tdata = 32'd1; tkeep = 4'hF; tlast = 1'b0;
        @(negedge clk);
        chk("lat_n0_tready", 32'(w_tready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_n1_tready", 32'(w_tready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_n2_tready", 32'(w_tready), 32'd1);
        @(posedge clk); #1;
        for (int i = 2; i <= 10; i++) send_beat(32'(i), 4'hF, i == 10);
        for (int i = 1; i <= 10; i++) push_exp(32'(i), (i == 10) ? 1'b0 : 1'b1, 1'b0);
        check_switch("t1");
        check_gaps("t1", 10, -1, -1);
        compare_strobes("t1");

        // T2 (dut_b, 8-word buffer): 20-beat packet splits 8/8/4.
        sel = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_beat(32'h200 + 32'(i), 4'hF, i == 19);
            push_exp(32'h200 + 32'(i), (i == 19) ? 1'b0 : 1'b1, 1'b0);
        end
        check_switch("t2");
        check_gaps("t2", 20, 8, 16);
        compare_strobes("t2");

        // T3: 8-beat packet exactly fills the buffer, so no pktend.
        for (int i = 0; i < 8; i++) begin
            send_beat(32'h400 + 32'(i), 4'hF, i == 7);
            push_exp(32'h400 + 32'(i), 1'b1, 1'b0);
        end
        check_switch("t3");
        compare_strobes("t3");

        // T4: flagb falls after the 3rd accept. One beat is already in flight
        // when the pin falls, then WM_BEATS=3 more, then a stall.
        acc = 0;
        guard = 0;
        tvalid = 1'b1; tkeep = 4'hF; tlast = 1'b0;
        while (acc < 3 && guard < 100) begin
            tdata = 32'h100 + 32'(acc);
            @(negedge clk);
            if (w_tready) acc++;
            @(posedge clk); #1;
            guard++;
        end
        flagb = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tdata = 32'h100 + 32'(acc);
            @(negedge clk);
            if (w_tready) acc++;
            @(posedge clk); #1;
        end
        chk("wm_accepts", 32'(acc), 32'd7);
        @(negedge clk);
        chk("wm_stall_tready", 32'(w_tready), 32'd0);
        @(posedge clk); #1;
        flagb = 1'b1;
        send_beat(32'h107, 4'hF, 1'b1);
        for (int i = 0; i < 8; i++) push_exp(32'h100 + 32'(i), 1'b1, 1'b0);
        check_switch("t4");
        compare_strobes("t4");

        // T5: tkeep masking and err_keep pulses.
        err_base = err_cnt;
        send_beat(32'h11111111, 4'hF, 1'b0);
        send_beat(32'h22334455, 4'b0111, 1'b0);
        send_beat(32'hAABBCCDD, 4'b0011, 1'b1);
        check_switch("t5a");
        send_beat(32'h12345678, 4'b0000, 1'b1);
        check_switch("t5b");
        push_exp(32'h11111111, 1'b1, 1'b0);
        push_exp(32'h00334455, 1'b1, 1'b1);
        push_exp(32'h0000CCDD, 1'b0, 1'b0);
        push_exp(32'h00000000, 1'b0, 1'b1);
        compare_strobes("t5");
        chk("t5_err_cycles", 32'(err_cnt - err_base), 32'd2);

        // T6: flaga drops for 5 cycles mid-buffer, fill count is kept,
        // then reset lands mid-packet.
        send_beat(32'h300, 4'hF, 1'b0);
        send_beat(32'h301, 4'hF, 1'b0);
        flaga = 1'b0;
        @(posedge clk); #1;
        tvalid = 1'b1; tdata = 32'h302; tkeep = 4'hF; tlast = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("t6_stall%0d", c), 32'(w_tready), 32'd0);
            @(posedge clk); #1;
        end
        flaga = 1'b1;
        for (int i = 2; i < 8; i++) send_beat(32'h300 + 32'(i), 4'hF, 1'b0);
        @(negedge clk);
        chk("t6_fill_switch", 32'(w_dbg), 32'(ST_SWITCH));
        @(posedge clk); #1;
        send_beat(32'h308, 4'hF, 1'b0);
        send_beat(32'h309, 4'hF, 1'b0);
        tvalid = 1'b1; tdata = 32'h30A; tkeep = 4'hF; tlast = 1'b1;
        areset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset_outputs("t6_rst", 2'b10);
        @(posedge clk); #1;
        areset = 1'b0; tvalid = 1'b0; tlast = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_slcs_after", 32'(w_slcs_n), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) push_exp(32'h300 + 32'(i), 1'b1, 1'b0);
        compare_strobes("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
